// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-setting logic: FSM encoding,
// digit positions, per-position digit limits and BCD bus packing helpers.
package watch_pkg;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_ENTRY = 2'd2;
  localparam logic [1:0] ST_LOAD  = 2'd3;

  // Entry positions, most significant digit first
  localparam logic [2:0] POS_H10 = 3'd0;
  localparam logic [2:0] POS_H1  = 3'd1;
  localparam logic [2:0] POS_M10 = 3'd2;
  localparam logic [2:0] POS_M1  = 3'd3;
  localparam logic [2:0] POS_S10 = 3'd4;
  localparam logic [2:0] POS_S1  = 3'd5;

  // Bit offsets of the hour digits on the 24-bit {h10,h1,m10,m1,s10,s1} bus
  localparam int H10_LSB = 20;
  localparam int H1_LSB  = 16;

  // LSB of the nibble holding the digit at a given entry position
  function automatic logic [4:0] digit_lsb(input logic [2:0] pos);
    case (pos)
      POS_H10: return 5'd20;
      POS_H1:  return 5'd16;
      POS_M10: return 5'd12;
      POS_M1:  return 5'd8;
      POS_S10: return 5'd4;
      default: return 5'd0;
    endcase
  endfunction

  // Largest digit accepted at a position; hour units depend on hour tens
  function automatic logic [3:0] max_digit(input logic [2:0] pos, input logic [3:0] h10);
    case (pos)
      POS_H10:          return 4'd2;
      POS_H1:           return (h10 == 4'd2) ? 4'd3 : 4'd9;
      POS_M10, POS_S10: return 4'd5;
      default:          return 4'd9;
    endcase
  endfunction

  // Replace one digit of a packed BCD time
  function automatic logic [23:0] set_digit(input logic [23:0] t, input logic [2:0] pos,
                                            input logic [3:0] d);
    logic [23:0] r;
    logic [4:0]  lsb;
    r   = t;
    lsb = digit_lsb(pos);
    r[lsb +: 4] = d;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: emits one key_valid pulse per press once a single key
// has been held stable long enough; the key must be released before the next.
module key_debounce #(
  parameter int DEBOUNCE = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] num_input,
  output logic       key_valid,
  output logic [3:0] key_digit
);

  localparam int             CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE);

  logic [9:0]    prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic          valid_q, valid_d;
  logic [3:0]    digit_q, digit_d;
  logic          one_hot;
  logic [3:0]    enc;

  assign one_hot = (num_input != '0) && ((num_input & (num_input - 10'd1)) == '0);

  // One-hot to binary digit encoder
  always_comb begin
    enc = '0;
    for (int k = 0; k < 10; k++) begin
      if (num_input[k]) enc = 4'(k);
    end
  end

  // Stability counting and release lock; the count restarts on any pattern change
  always_comb begin
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    valid_d = 1'b0;
    digit_d = digit_q;
    if (!one_hot)                cnt_d = '0;
    else if (num_input != prev_q) cnt_d = CW'(1);
    else if (cnt_q != CNT_MAX)   cnt_d = cnt_q + 1'b1;
    if (num_input == '0) begin
      lock_d = 1'b0;
    end else if (one_hot && !lock_q && cnt_d == CNT_MAX) begin
      valid_d = 1'b1;
      digit_d = enc;
      lock_d  = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      valid_q <= 1'b0;
      digit_q <= '0;
    end else begin
      prev_q  <= num_input;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      digit_q <= digit_d;
    end
  end

  assign key_valid = valid_q;
  assign key_digit = digit_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad time-entry sequencer: captures the running time, lets the user
// overwrite it digit by digit and strobes the result into the watch core.
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ     = 1000,
  parameter int DEBOUNCE   = CLK_HZ / 50,
  parameter int TIMEOUT    = CLK_HZ * 10,
  parameter int BLINK_HALF = CLK_HZ / 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_time,
  input  logic        cancel,
  input  logic [9:0]  num_input,
  input  logic [23:0] cur_time,
  output logic [23:0] time_bcd,
  output logic        load_time,
  output logic        busy,
  output logic [2:0]  digit_pos,
  output logic [5:0]  blink_mask,
  output logic        key_err
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam int            BW         = $clog2(BLINK_HALF + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    pos_q, pos_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [23:0]   time_bcd_q, time_bcd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          key_err_q, key_err_d;
  logic          set_prev_q, cancel_prev_q;
  logic          set_edge, cancel_edge;
  logic          key_valid;
  logic [3:0]    key_digit;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_debounce (
    .clk       (clk),
    .rst       (rst),
    .num_input (num_input),
    .key_valid (key_valid),
    .key_digit (key_digit)
  );

  assign set_edge    = set_time & ~set_prev_q;
  assign cancel_edge = cancel & ~cancel_prev_q;

  // Sequencer next-state: exits from ENTRY are ranked cancel > set > timeout > key
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    shadow_d    = shadow_q;
    time_bcd_d  = time_bcd_q;
    tmo_d       = tmo_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    key_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (set_edge) state_d = ST_ARM;
      end
      ST_ARM: begin
        shadow_d    = cur_time;
        pos_d       = POS_H10;
        tmo_d       = '0;
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        state_d     = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
        if (cancel_edge) begin
          state_d = ST_IDLE;
        end else if (set_edge) begin
          state_d    = ST_LOAD;
          time_bcd_d = shadow_q;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
        end else if (key_valid) begin
          tmo_d = '0;
          if (key_digit <= max_digit(pos_q, shadow_q[H10_LSB +: 4])) begin
            shadow_d = set_digit(shadow_q, pos_q, key_digit);
            // Entering 2x hours: a captured hour unit above 3 would be illegal
            if (pos_q == POS_H10 && key_digit == 4'd2 && shadow_q[H1_LSB +: 4] > 4'd3)
              shadow_d[H1_LSB +: 4] = 4'd0;
            if (pos_q == POS_S1) begin
              state_d    = ST_LOAD;
              time_bcd_d = shadow_d;
            end else begin
              pos_d       = pos_q + 3'd1;
              blink_cnt_d = '0;
              blink_on_d  = 1'b1;
            end
          end else begin
            key_err_d = 1'b1;
          end
        end else if (tmo_q != TMO_LAST) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      pos_q         <= '0;
      shadow_q      <= '0;
      time_bcd_q    <= '0;
      tmo_q         <= '0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b0;
      key_err_q     <= 1'b0;
      set_prev_q    <= 1'b0;
      cancel_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      shadow_q      <= shadow_d;
      time_bcd_q    <= time_bcd_d;
      tmo_q         <= tmo_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      key_err_q     <= key_err_d;
      set_prev_q    <= set_time;
      cancel_prev_q <= cancel;
    end
  end

  assign time_bcd   = time_bcd_q;
  assign load_time  = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign digit_pos  = (state_q == ST_ENTRY) ? pos_q : 3'd0;
  assign blink_mask = (state_q == ST_ENTRY && blink_on_q) ? (6'b100000 >> pos_q) : 6'b000000;
  assign key_err    = key_err_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: table of entry scenarios, hand-written
// corner sequences and randomized entries checked against a digit-level model.
module tb_time_set_ctrl;

  localparam int DEB = 20;
  localparam int TMO = 10000;
  localparam int BH  = 250;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        set_time = 1'b0;
  logic        cancel = 1'b0;
  logic [9:0]  num_input = '0;
  logic [23:0] cur_time = '0;
  logic [23:0] time_bcd;
  logic        load_time;
  logic        busy;
  logic [2:0]  digit_pos;
  logic [5:0]  blink_mask;
  logic        key_err;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int err_cnt = 0;

  time_set_ctrl #(.CLK_HZ(1000), .DEBOUNCE(DEB), .TIMEOUT(TMO), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .set_time(set_time), .cancel(cancel), .num_input(num_input),
    .cur_time(cur_time), .time_bcd(time_bcd), .load_time(load_time), .busy(busy),
    .digit_pos(digit_pos), .blink_mask(blink_mask), .key_err(key_err)
  );

  always #5 clk = ~clk;

  // Count strobes away from the active edge
  always @(negedge clk) begin
    if (load_time === 1'b1) load_cnt <= load_cnt + 1;
    if (key_err === 1'b1)   err_cnt  <= err_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic [23:0] cur;
    string       keys;
    bit          early;
    logic [23:0] exp_bcd;
    int          exp_errs;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a key for 'hold' clock edges, release, and return one edge after release
  task automatic press(input int d, input int hold);
    num_input = 10'b1 << d;
    tick(hold);
    num_input = '0;
    tick(1);
  endtask

  task automatic start_entry(input logic [23:0] cur);
    cur_time = cur;
    set_time = 1'b1;
    tick(1);
    set_time = 1'b0;
    tick(1);
  endtask

  task automatic set_vec(input int i, input logic [23:0] cur, input string keys, input bit early,
                         input logic [23:0] bcd, input int errs);
    tbl[i].cur = cur; tbl[i].keys = keys; tbl[i].early = early;
    tbl[i].exp_bcd = bcd; tbl[i].exp_errs = errs;
  endtask

  function automatic logic [39:0] str2keys(input string s);
    logic [39:0] k;
    k = '0;
    for (int i = 0; i < s.len(); i++) k[i*4 +: 4] = 4'(s[i] - 8'd48);
    return k;
  endfunction

  // Digit-level model: walk the key list applying the range and fix-up rules
  function automatic void model(input logic [23:0] cur, input logic [39:0] k, input int n,
                                output logic [23:0] bcd, output int errs, output int used,
                                output bit done);
    int d[6];
    int pos, key, lim;
    for (int i = 0; i < 6; i++) d[i] = int'(cur[(5-i)*4 +: 4]);
    pos = 0; errs = 0; used = 0; done = 1'b0;
    for (int i = 0; i < n && !done; i++) begin
      key = int'(k[i*4 +: 4]);
      used++;
      case (pos)
        0:       lim = 2;
        1:       lim = (d[0] == 2) ? 3 : 9;
        2, 4:    lim = 5;
        default: lim = 9;
      endcase
      if (key > lim) errs++;
      else begin
        d[pos] = key;
        if (pos == 0 && key == 2 && d[1] > 3) d[1] = 0;
        pos++;
        if (pos == 6) done = 1'b1;
      end
    end
    bcd = '0;
    for (int i = 0; i < 6; i++) bcd[(5-i)*4 +: 4] = 4'(d[i]);
  endfunction

  // Run one entry: given keys, optional early commit, and check the load result
  task automatic run_entry(input string tag, input logic [23:0] cur, input logic [39:0] k,
                           input int n, input bit early, input bit rand_hold,
                           input logic [23:0] exp_bcd, input int exp_errs);
    int l0, e0;
    l0 = load_cnt; e0 = err_cnt;
    start_entry(cur);
    for (int i = 0; i < n; i++) begin
      if (rand_hold && i != n - 1) begin
        press(int'(k[i*4 +: 4]), DEB + int'($urandom_range(0, 15)));
        tick(int'($urandom_range(0, 3)));
      end else begin
        press(int'(k[i*4 +: 4]), DEB);
      end
    end
    if (early) begin
      set_time = 1'b1;
      tick(1);
      set_time = 1'b0;
    end
    check({tag, "_load_strobe"}, {31'd0, load_time}, 32'd1);
    check({tag, "_time_bcd"}, {8'd0, time_bcd}, {8'd0, exp_bcd});
    tick(1);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_load_count"}, load_cnt - l0, 32'd1);
    check({tag, "_key_errs"}, err_cnt - e0, exp_errs);
    $display("entry %s cur=%06h keys=%0d early=%0d bcd=%06h errs=%0d", tag, cur, n, early,
             time_bcd, err_cnt - e0);
    tick(2);
  endtask

  logic [23:0] rcur, rbcd;
  logic [39:0] rkeys;
  int          rn, rerrs, rused, l0, e0;
  bit          rdone;

  initial begin
    set_vec(0, 24'h123456, "235959",   1'b0, 24'h235959, 0);
    set_vec(1, 24'h000000, "32435959", 1'b0, 24'h235959, 2);
    set_vec(2, 24'h081500, "10",       1'b1, 24'h101500, 0);
    set_vec(3, 24'h190000, "2",        1'b1, 24'h200000, 0);
    set_vec(4, 24'h235959, "076593",   1'b1, 24'h075939, 1);
    set_vec(5, 24'h145020, "24",       1'b1, 24'h205020, 1);

    // Reset state
    tick(3);
    check("rst_time_bcd", {8'd0, time_bcd}, 32'd0);
    check("rst_load", {31'd0, load_time}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pos", {29'd0, digit_pos}, 32'd0);
    check("rst_blink", {26'd0, blink_mask}, 32'd0);
    check("rst_key_err", {31'd0, key_err}, 32'd0);
    rst = 1'b1;
    tick(2);

    // Table-driven entries
    for (int v = 0; v < 6; v++)
      run_entry($sformatf("vec%0d", v), tbl[v].cur, str2keys(tbl[v].keys), tbl[v].keys.len(),
                tbl[v].early, 1'b0, tbl[v].exp_bcd, tbl[v].exp_errs);

    // Range rejects, blink phase, debounce corners, cancel
    l0 = load_cnt;
    start_entry(24'h000000);
    check("arm_busy", {31'd0, busy}, 32'd1);
    check("arm_blink", {26'd0, blink_mask}, 32'h20);
    press(3, DEB);
    check("rej0_err", {31'd0, key_err}, 32'd1);
    check("rej0_pos", {29'd0, digit_pos}, 32'd0);
    tick(1);
    check("rej0_err_pulse", {31'd0, key_err}, 32'd0);
    press(2, DEB);
    check("acc0_pos", {29'd0, digit_pos}, 32'd1);
    check("acc0_blink", {26'd0, blink_mask}, 32'h10);
    press(4, DEB);
    check("rej1_err", {31'd0, key_err}, 32'd1);
    check("rej1_pos", {29'd0, digit_pos}, 32'd1);
    press(1, DEB - 1);
    check("short_hold_pos", {29'd0, digit_pos}, 32'd1);
    press(1, DEB);
    check("acc1_pos", {29'd0, digit_pos}, 32'd2);
    tick(BH - 1);
    check("blink_visible", {26'd0, blink_mask}, 32'h08);
    tick(1);
    check("blink_hidden", {26'd0, blink_mask}, 32'd0);
    tick(BH);
    check("blink_back", {26'd0, blink_mask}, 32'h08);
    num_input = 10'b0000000110;
    tick(40);
    num_input = '0;
    tick(2);
    check("two_keys_pos", {29'd0, digit_pos}, 32'd2);
    e0 = err_cnt;
    press(5, 500);
    check("long_hold_pos", {29'd0, digit_pos}, 32'd3);
    check("long_hold_errs", err_cnt - e0, 32'd0);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    tick(2);
    check("cancel_no_load", load_cnt - l0, 32'd0);
    $display("seq cancel_and_debounce done");

    // Timeout at position 3
    l0 = load_cnt;
    start_entry(24'h123456);
    press(1, DEB); press(2, DEB); press(3, DEB);
    check("tmo_pos", {29'd0, digit_pos}, 32'd3);
    tick(TMO - 5);
    check("tmo_busy_before", {31'd0, busy}, 32'd1);
    tick(10);
    check("tmo_busy_after", {31'd0, busy}, 32'd0);
    check("tmo_pos_after", {29'd0, digit_pos}, 32'd0);
    check("tmo_no_load", load_cnt - l0, 32'd0);
    $display("seq timeout done");

    // Reset at position 4
    l0 = load_cnt;
    start_entry(24'h123456);
    press(1, DEB); press(2, DEB); press(3, DEB); press(4, DEB);
    check("rst4_pos", {29'd0, digit_pos}, 32'd4);
    rst = 1'b0;
    tick(1);
    check("rst4_busy", {31'd0, busy}, 32'd0);
    check("rst4_time_bcd", {8'd0, time_bcd}, 32'd0);
    check("rst4_pos_after", {29'd0, digit_pos}, 32'd0);
    check("rst4_blink", {26'd0, blink_mask}, 32'd0);
    check("rst4_load", {31'd0, load_time}, 32'd0);
    rst = 1'b1;
    tick(3);
    check("rst4_no_load", load_cnt - l0, 32'd0);
    $display("seq reset_mid_entry done");

    // Cancel and set edges in the same cycle
    l0 = load_cnt;
    start_entry(24'h010203);
    press(1, DEB);
    cancel = 1'b1; set_time = 1'b1;
    tick(1);
    cancel = 1'b0; set_time = 1'b0;
    check("both_busy", {31'd0, busy}, 32'd0);
    check("both_load", {31'd0, load_time}, 32'd0);
    tick(3);
    check("both_no_load", load_cnt - l0, 32'd0);
    $display("seq cancel_with_set done");

    // Randomized entries against the model
    for (int it = 0; it < 24; it++) begin
      rcur[23:20] = 4'($urandom_range(0, 2));
      rcur[19:16] = (rcur[23:20] == 4'd2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 9));
      rcur[15:12] = 4'($urandom_range(0, 5));
      rcur[11:8]  = 4'($urandom_range(0, 9));
      rcur[7:4]   = 4'($urandom_range(0, 5));
      rcur[3:0]   = 4'($urandom_range(0, 9));
      rn = int'($urandom_range(1, 10));
      rkeys = '0;
      for (int i = 0; i < rn; i++) rkeys[i*4 +: 4] = 4'($urandom_range(0, 9));
      model(rcur, rkeys, rn, rbcd, rerrs, rused, rdone);
      run_entry($sformatf("rnd%0d", it), rcur, rkeys, rused, !rdone, 1'b1, rbcd, rerrs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
